change_dispenser: RTL
=====================

# change_dispenser

Serial change-dispensing engine for the vending machine. It accepts a refund amount, typically the machine's current total when a return is triggered or the wait time expires. It pays the amount out greedily, one physical coin at a time, over a request/acknowledge handshake with the coin hopper, and it keeps a per-denomination inventory. It reports any amount it could not pay because stock ran out.

## Interface
Parameters:
- `TOTAL_BITS`, default 31: width of amount and remainder.
- `COIN_VAL0`, default 100: value of coin type 0.
- `COIN_VAL1`, default 500: value of coin type 1.
- `COIN_VAL2`, default 1000: value of coin type 2.
- `INV_BITS`, default 8: width of each inventory counter.
- `INIT_INV`, default 4: inventory of each type after reset.

Ports:
- `clk` input 1: clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `i_start` input 1: single-cycle request to dispense `i_amount`.
- `i_amount` input TOTAL_BITS: amount to refund; sampled only when `i_start` is accepted.
- `i_refill` input 3: bit k high adds one coin of type k to inventory in that cycle.
- `i_coin_ack` input 1: hopper has released the coin currently requested on `o_coin`.
- `o_coin` output 3: one-hot dispense request; at most one bit set.
- `o_busy` output 1: high in every non-IDLE state.
- `o_done` output 1: one-cycle pulse when a refund finishes.
- `o_short` output 1: valid with `o_done`; high if `o_remainder` is nonzero.
- `o_remainder` output TOTAL_BITS: amount still unpaid; valid from `o_done` until the next accepted `i_start`.
- `o_inv0`, `o_inv1`, `o_inv2` output INV_BITS: current inventory counts.

## Operation
- Registers:
  - `remaining`, TOTAL_BITS.
  - `inv[0..2]`, INV_BITS each.
  - `sel`, 3-bit one-hot.
  - State: IDLE, SELECT, DISPENSE, DONE.
- IDLE:
  - `i_start`=1 loads `remaining` from `i_amount`.
  - Next state is SELECT.
- SELECT, greedy pick in priority order type 2, then 1, then 0:
  - Pick the first type with `remaining` ≥ COIN_VALk and `inv[k]` > 0.
  - If a type is found: load `sel`, go to DISPENSE.
  - If none is found: go to DONE. This covers both `remaining`=0 and an inventory shortfall.
- DISPENSE:
  - `o_coin`=`sel` is held steady until `i_coin_ack` is sampled high.
  - On ack: `remaining` -= COIN_VALk, `inv[k]` -= 1, `sel` cleared, go to SELECT.
  - Without ack: stay in DISPENSE indefinitely. There is no timeout.
- DONE:
  - `o_done`=1 for one cycle.
  - `o_remainder`=`remaining`; `o_short`=(`remaining`≠0).
  - Next state is IDLE.
- Arithmetic:
  - Subtraction is guarded by the SELECT comparison, so `remaining` never underflows.
  - All comparisons are unsigned, at TOTAL_BITS width.
- Inventory:
  - Refill adds +1 per set bit and saturates at 2^INV_BITS−1.
  - Refill and ack on the same type in the same cycle leave the count unchanged.
  - Refill is accepted in any state, including IDLE.
- `i_start` is ignored whenever `o_busy`=1; a request made while busy is not queued.
- `i_coin_ack` outside DISPENSE is ignored.

## Timing
- Reset, asynchronous:
  - State=IDLE.
  - `o_coin`=0, `o_busy`=0, `o_done`=0, `o_short`=0, `o_remainder`=0.
  - `remaining`=0; every `inv[k]`=INIT_INV.
- Reset mid-dispense aborts immediately. No completion pulse is produced and the in-flight coin is not counted.
- All outputs are registered; nothing propagates combinationally from input to output.
- Per-refund timing, with `i_start` accepted at edge 0:
  - SELECT at cycle 1.
  - `o_coin` valid from cycle 2.
  - An ack sampled at edge n returns the block to SELECT at n+1, with the next `o_coin` at n+2.
  - Minimum of 2 cycles per coin when ack is tied high.
- Zero amount: start at edge 0, SELECT at cycle 1, `o_done` at cycle 2 with remainder 0.
- An N-coin refund with immediate acks completes with `o_done` at cycle 2N+2.
- `o_busy` rises the cycle after `i_start` is accepted and falls the cycle after `o_done`.

## Test plan
- Reset, then `i_start` with `i_amount`=1600, `i_coin_ack` tied 1:
  - `o_coin` sequence is 100b, 010b, 001b.
  - `o_done` at cycle 8, remainder 0, `o_short`=0.
  - Inventories end at 3, 3, 3.
- Set `inv2`=1, then amount 2300, ack tied 1:
  - Coins dispensed: type 2 once, type 1 twice, type 0 three times.
  - Remainder 0.
  - Inventories end at `inv0`=1, `inv1`=2, `inv2`=0.
- Set `inv0`=2 and `inv1`=`inv2`=0, then amount 300:
  - Two type-0 coins are dispensed.
  - `o_done` with `o_short`=1 and `o_remainder`=100.
- Ack withheld for 5 cycles on the first coin:
  - `o_coin` stays stable for all 5 cycles.
  - A second `i_start` pulsed during the wait is ignored.
  - The first refund completes normally.
- Refill:
  - Pulse `i_refill`=001b during a type-0 ack: `inv0` is unchanged.
  - Refill 300 times in IDLE: `inv0` saturates at 255.
- Assert `reset_n`=0 mid-DISPENSE:
  - `o_coin` and `o_busy` drop without waiting for a clock edge.
  - `inv` returns to 4, 4, 4.
  - No `o_done` pulse is produced.

Source files
------------

// File: rtl/change_dispenser.sv
// Serial change dispenser: pays a refund greedily one coin at a time over a
// request/acknowledge handshake with the hopper and tracks per-type inventory.
module change_dispenser #(
  parameter int TOTAL_BITS = 31,
  parameter int COIN_VAL0  = 100,
  parameter int COIN_VAL1  = 500,
  parameter int COIN_VAL2  = 1000,
  parameter int INV_BITS   = 8,
  parameter int INIT_INV   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic [TOTAL_BITS-1:0] i_amount,
  input  logic [2:0]            i_refill,
  input  logic                  i_coin_ack,
  output logic [2:0]            o_coin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_short,
  output logic [TOTAL_BITS-1:0] o_remainder,
  output logic [INV_BITS-1:0]   o_inv0,
  output logic [INV_BITS-1:0]   o_inv1,
  output logic [INV_BITS-1:0]   o_inv2
);

  localparam logic [TOTAL_BITS-1:0] VAL0 = TOTAL_BITS'(COIN_VAL0);
  localparam logic [TOTAL_BITS-1:0] VAL1 = TOTAL_BITS'(COIN_VAL1);
  localparam logic [TOTAL_BITS-1:0] VAL2 = TOTAL_BITS'(COIN_VAL2);
  localparam logic [INV_BITS-1:0]   INV_MAX   = {INV_BITS{1'b1}};
  localparam logic [INV_BITS-1:0]   INV_RESET = INV_BITS'(INIT_INV);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    DISPENSE,
    DONE
  } state_t;

  state_t                        state, state_next;
  logic [TOTAL_BITS-1:0]         remaining, remaining_next;
  logic [2:0]                    sel, sel_next;
  logic [2:0][INV_BITS-1:0]      inv, inv_next;
  logic [2:0]                    can_pay;
  logic [2:0]                    pick;
  logic [TOTAL_BITS-1:0]         sel_val;
  logic                          ack_fire;

  // A type is payable only if it fits in what is left and is in stock.
  assign can_pay[0] = (remaining >= VAL0) && (inv[0] != '0);
  assign can_pay[1] = (remaining >= VAL1) && (inv[1] != '0);
  assign can_pay[2] = (remaining >= VAL2) && (inv[2] != '0);

  assign pick = can_pay[2] ? 3'b100 :
                can_pay[1] ? 3'b010 :
                can_pay[0] ? 3'b001 : 3'b000;

  assign sel_val  = sel[2] ? VAL2 : (sel[1] ? VAL1 : VAL0);
  assign ack_fire = (state == DISPENSE) && i_coin_ack;

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    sel_next       = sel;
    case (state)
      IDLE: begin
        if (i_start) begin
          remaining_next = i_amount;
          state_next     = SELECT;
        end
      end
      SELECT: begin
        if (pick != 3'b000) begin
          sel_next   = pick;
          state_next = DISPENSE;
        end else begin
          state_next = DONE;
        end
      end
      DISPENSE: begin
        if (i_coin_ack) begin
          remaining_next = remaining - sel_val;
          sel_next       = 3'b000;
          state_next     = SELECT;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A refill and a release of the same type in one cycle cancel each other.
  always_comb begin
    inv_next = inv;
    for (int k = 0; k < 3; k++) begin
      case ({i_refill[k], ack_fire && sel[k]})
        2'b10: begin
          if (inv[k] != INV_MAX) begin
            inv_next[k] = inv[k] + 1'b1;
          end
        end
        2'b01: begin
          inv_next[k] = inv[k] - 1'b1;
        end
        default: begin
          inv_next[k] = inv[k];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      remaining <= '0;
      sel       <= 3'b000;
      inv       <= {3{INV_RESET}};
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      sel       <= sel_next;
      inv       <= inv_next;
    end
  end

  // Outputs are computed from next-state values so they line up with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_coin      <= 3'b000;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_short     <= 1'b0;
      o_remainder <= '0;
    end else begin
      o_coin <= (state_next == DISPENSE) ? sel_next : 3'b000;
      o_busy <= (state_next != IDLE);
      o_done <= (state_next == DONE);
      if (state_next == DONE) begin
        o_remainder <= remaining_next;
        o_short     <= (remaining_next != '0);
      end
    end
  end

  assign o_inv0 = inv[0];
  assign o_inv1 = inv[1];
  assign o_inv2 = inv[2];

endmodule
